// File: rtl/core_boot_sequencer_pkg.sv
// Shared types and defaults for the staggered per-core reset-release sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_boot_sequencer_pkg;

  localparam int DEFAULT_NUM_CORES    = 4;
  localparam int BOOT_STAGGER_DEFAULT = 16;
  localparam int BOOT_TIMEOUT_DEFAULT = 1024;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SCAN     = 3'd1,
    STAGGER  = 3'd2,
    WAIT_RDY = 3'd3,
    DONE     = 3'd4,
    FAIL     = 3'd5
  } boot_seq_state_e;

  // Core index width; a single-core system still needs one bit.
  function automatic int boot_idx_w(input int num_cores);
    return (num_cores > 1) ? $clog2(num_cores) : 1;
  endfunction

endpackage

// File: rtl/core_boot_sequencer_if.sv
// Control/status bundle between the system controller and the boot sequencer.
// Latency: n/a (wires only).
// Backpressure: none; ready acknowledges are level signals sampled by the sequencer.
interface core_boot_sequencer_if
  import core_boot_sequencer_pkg::*;
#(
  parameter int NUM_CORES = DEFAULT_NUM_CORES
);
  localparam int CORE_IDX_W = boot_idx_w(NUM_CORES);

  logic                  start_i;
  logic [NUM_CORES-1:0]  core_en_mask_i;
  logic                  shutdown_i;
  logic [NUM_CORES-1:0]  core_ready_i;
  logic [NUM_CORES-1:0]  core_rst_no;
  logic                  busy_o;
  logic                  done_o;
  logic                  fail_o;
  logic [CORE_IDX_W-1:0] fail_core_o;

  // System controller / core side.
  modport master (
    output start_i, core_en_mask_i, shutdown_i, core_ready_i,
    input  core_rst_no, busy_o, done_o, fail_o, fail_core_o
  );

  // Sequencer side.
  modport slave (
    input  start_i, core_en_mask_i, shutdown_i, core_ready_i,
    output core_rst_no, busy_o, done_o, fail_o, fail_core_o
  );
endinterface

// File: rtl/core_boot_sequencer_counter.sv
// Loadable, saturating up-counter with clear and terminal-count compare.
// Latency: count visible one cycle after inc/clr/load; tc_o is combinational on the count.
// Backpressure: none; saturates at all-ones so it can never wrap.
module boot_cycle_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             inc_i,
  input  logic [CNT_W-1:0] tc_val_i,
  output logic             tc_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear beats load beats increment; hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == tc_val_i);
endmodule

// File: rtl/core_boot_sequencer.sv
// Releases enabled per-core resets one at a time in ascending order, with a stagger delay and ready handshake.
// Latency: first release STAGGER_CYCLES+1+idx edges after start; all outputs registered.
// Backpressure: waits on each core's ready; optional watchdog via BOOT_SEQ_TIMEOUT_EN.
module core_boot_sequencer
  import core_boot_sequencer_pkg::*;
#(
  parameter int NUM_CORES      = DEFAULT_NUM_CORES,
  parameter int STAGGER_CYCLES = BOOT_STAGGER_DEFAULT,
  parameter int TIMEOUT_CYCLES = BOOT_TIMEOUT_DEFAULT
) (
  input logic                 clk_i,
  input logic                 rst_i,
  core_boot_sequencer_if.slave bus
);
  localparam int CORE_IDX_W = boot_idx_w(NUM_CORES);
  localparam int IDX_W      = CORE_IDX_W + 1;
  localparam int CNT_MAX    = (STAGGER_CYCLES > TIMEOUT_CYCLES) ? STAGGER_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  boot_seq_state_e      state_q, state_d;
  logic [NUM_CORES-1:0] mask_q, mask_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [NUM_CORES-1:0] rst_n_q, rst_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [NUM_CORES-1:0] cur_onehot;
  logic                 cur_mask;
  logic                 cur_ready;
  logic                 cnt_clr, cnt_inc, cnt_tc;
  logic [CNT_W-1:0]     cnt_tc_val;

  // Decode the core currently pointed at; idx==NUM_CORES selects none.
  always_comb begin
    cur_onehot = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cur_onehot[i] = (idx_q == IDX_W'(i));
    end
  end

  assign cur_mask  = |(mask_q & cur_onehot);
  assign cur_ready = |(bus.core_ready_i & cur_onehot);

`ifdef BOOT_SEQ_TIMEOUT_EN
  logic                  fail_q, fail_d;
  logic [CORE_IDX_W-1:0] fail_core_q, fail_core_d;
  logic                  timeout_hit;

  // Ready arriving on the terminal cycle wins over the watchdog.
  assign timeout_hit = (state_q == WAIT_RDY) && !cur_ready && cnt_tc;
  assign cnt_tc_val  = (state_q == WAIT_RDY) ? CNT_W'(TIMEOUT_CYCLES - 1) : CNT_W'(STAGGER_CYCLES - 1);
`else
  assign cnt_tc_val  = CNT_W'(STAGGER_CYCLES - 1);
`endif

  boot_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (cnt_clr),
    .load_i     (1'b0),
    .load_val_i ({CNT_W{1'b0}}),
    .inc_i      (cnt_inc),
    .tc_val_i   (cnt_tc_val),
    .tc_o       (cnt_tc)
  );

  // State, index, captured mask and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state; shutdown overrides everything and returns to IDLE.
  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (bus.shutdown_i) begin
      state_d = IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            mask_d  = bus.core_en_mask_i;
            idx_d   = '0;
            state_d = SCAN;
          end
        end
        SCAN: begin
          if ((mask_q == '0) || (idx_q == IDX_W'(NUM_CORES))) begin
            state_d = DONE;
          end else if (cur_mask) begin
            cnt_clr = 1'b1;
            state_d = STAGGER;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        STAGGER: begin
          if (cnt_tc) begin
            cnt_clr = 1'b1;
            state_d = WAIT_RDY;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        WAIT_RDY: begin
          if (cur_ready) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = SCAN;
`ifdef BOOT_SEQ_TIMEOUT_EN
          end else if (timeout_hit) begin
            state_d = FAIL;
`endif
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: ;  // DONE / FAIL hold until shutdown or reset
      endcase
    end
  end

  // Registered output next-values, derived from the upcoming state.
  always_comb begin
    rst_n_d = rst_n_q;
    busy_d  = (state_d == SCAN) || (state_d == STAGGER) || (state_d == WAIT_RDY);
    done_d  = (state_d == DONE);
    if (bus.shutdown_i) begin
      rst_n_d = '0;
    end else if ((state_q == STAGGER) && cnt_tc) begin
      rst_n_d = rst_n_q | cur_onehot;
`ifdef BOOT_SEQ_TIMEOUT_EN
    end else if (timeout_hit) begin
      rst_n_d = rst_n_q & ~cur_onehot;
`endif
    end
  end

`ifdef BOOT_SEQ_TIMEOUT_EN
  // Failure flag and the index of the core that never answered.
  always_comb begin
    fail_d      = (state_d == FAIL);
    fail_core_d = fail_core_q;
    if (bus.shutdown_i)  fail_core_d = '0;
    else if (timeout_hit) fail_core_d = idx_q[CORE_IDX_W-1:0];
  end

  // Failure status registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fail_q      <= 1'b0;
      fail_core_q <= '0;
    end else begin
      fail_q      <= fail_d;
      fail_core_q <= fail_core_d;
    end
  end

  assign bus.fail_o      = fail_q;
  assign bus.fail_core_o = fail_core_q;
`else
  assign bus.fail_o      = 1'b0;
  assign bus.fail_core_o = '0;
`endif

  assign bus.core_rst_no = rst_n_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_o      = done_q;
endmodule

// File: tb/tb_core_boot_sequencer.sv
// Bench for core_boot_sequencer: timestamp-based reference model plus pinned literal checks.
// Latency: n/a.
// Backpressure: core ready responder answers each released core after a fixed delay.
module tb_core_boot_sequencer;
  localparam int N = 4;
  localparam int S = 16;
  localparam int T = 32;
`ifdef BOOT_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  core_boot_sequencer_if #(.NUM_CORES(N)) bus ();

  core_boot_sequencer #(
    .NUM_CORES      (N),
    .STAGGER_CYCLES (S),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int e0    = 0;

  wire [8:0] outs = {bus.core_rst_no, bus.busy_o, bus.done_o, bus.fail_o, bus.fail_core_o};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  // ---------------- reference model (edge timestamps) ----------------
  typedef enum {P_IDLE, P_REL, P_WAIT, P_FIN, P_END} phase_e;
  phase_e     phase = P_IDLE;
  logic [3:0] m_mask  = '0;
  logic [3:0] m_rst_n = '0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_fail = 1'b0;
  logic [1:0] m_fail_core = '0;
  int cur = 0, ev = 0, rel = 0, nxt = 0;

  function automatic int first_en(input logic [3:0] msk, input int after);
    for (int i = after + 1; i < N; i++) if (msk[i]) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst || bus.shutdown_i) begin
      m_rst_n = '0; m_busy = 0; m_done = 0; m_fail = 0; m_fail_core = '0;
      phase = P_IDLE;
    end else begin
      case (phase)
        P_IDLE: if (bus.start_i) begin
          m_mask = bus.core_en_mask_i;
          m_busy = 1;
          nxt = first_en(m_mask, -1);
          if (nxt < 0) begin ev = cyc + 1; phase = P_FIN; end
          else begin cur = nxt; ev = cyc + (nxt + 1) + S; phase = P_REL; end
        end
        P_REL: if (cyc == ev) begin
          m_rst_n[cur] = 1'b1; rel = cyc; phase = P_WAIT;
        end
        P_WAIT: if (bus.core_ready_i[cur]) begin
          nxt = first_en(m_mask, cur);
          if (nxt < 0) begin ev = cyc + (N - cur); phase = P_FIN; end
          else begin ev = cyc + (nxt - cur) + S; cur = nxt; phase = P_REL; end
        end else if (TMO_EN && cyc == rel + T) begin
          m_rst_n[cur] = 1'b0; m_fail = 1; m_fail_core = 2'(cur); m_busy = 0;
          phase = P_END;
        end
        P_FIN: if (cyc == ev) begin
          m_done = 1; m_busy = 0; phase = P_END;
        end
        default: ;
      endcase
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cyc >= 1) chk("outs_vs_model", 32'(outs), 32'({m_rst_n, m_busy, m_done, m_fail, m_fail_core}));
  end

  // ---------------- ready responder ----------------
  logic [3:0] ready_ok = 4'b1111;
  logic [3:0] spur     = 4'b0000;
  logic [3:0] auto_rdy = 4'b0000;
  bit         seen[N];
  int         rel_at[N];

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (bus.core_rst_no[i] !== 1'b1) begin
        seen[i] = 0; auto_rdy[i] = 1'b0;
      end else begin
        if (!seen[i]) begin seen[i] = 1; rel_at[i] = cyc; end
        if (ready_ok[i] && cyc >= rel_at[i] + 2) auto_rdy[i] = 1'b1;
      end
    end
    bus.core_ready_i = auto_rdy | spur;
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic at_cycle(input int k);
    while (cyc < k) @(negedge clk);
    if (cyc != k) begin
      n_cmp++; n_bad++;
      $display("FAIL at_cycle: now %0d want %0d", cyc, k);
    end
  endtask

  task automatic do_start(input logic [3:0] msk);
    bus.start_i = 1'b1; bus.core_en_mask_i = msk;
    e0 = cyc + 1;
    @(negedge clk);
    bus.start_i = 1'b0;
  endtask

  task automatic shutdown_pulse();
    bus.shutdown_i = 1'b1;
    @(negedge clk);
    bus.shutdown_i = 1'b0;
    chk("shutdown_outs", 32'(outs), 32'd0);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.core_en_mask_i = '0; bus.shutdown_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'(outs), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full mask, ready 3 cycles after each release.
    do_start(4'b1111);
    chk("t1_busy_e0", 32'(bus.busy_o), 32'd1);
    at_cycle(e0 + 16); chk("t1_rst_e16", 32'(bus.core_rst_no), 32'b0000);
    at_cycle(e0 + 17); chk("t1_rst_e17", 32'(bus.core_rst_no), 32'b0001);
    at_cycle(e0 + 37); chk("t1_rst_e37", 32'(bus.core_rst_no), 32'b0011);
    at_cycle(e0 + 57); chk("t1_rst_e57", 32'(bus.core_rst_no), 32'b0111);
    at_cycle(e0 + 77); chk("t1_rst_e77", 32'(bus.core_rst_no), 32'b1111);
    at_cycle(e0 + 80); chk("t1_done_e80", 32'(bus.done_o), 32'd0);
    at_cycle(e0 + 81); chk("t1_done_e81", 32'(bus.done_o), 32'd1);
    chk("t1_fail", 32'(bus.fail_o), 32'd0);
    // Start while DONE is ignored.
    do_start(4'b0001);
    repeat (5) @(negedge clk);
    chk("t1_done_hold", 32'({bus.core_rst_no, bus.done_o, bus.busy_o}), 32'b1111_1_0);
    shutdown_pulse();

    // Sparse mask with spurious ready on cores not being waited on.
    spur = 4'b0101;
    do_start(4'b1010);
    at_cycle(e0 + 17); chk("t2_rst_e17", 32'(bus.core_rst_no), 32'b0000);
    at_cycle(e0 + 18); chk("t2_rst_e18", 32'(bus.core_rst_no), 32'b0010);
    at_cycle(e0 + 39); chk("t2_rst_e39", 32'(bus.core_rst_no), 32'b1010);
    at_cycle(e0 + 42); chk("t2_done_e42", 32'(bus.done_o), 32'd0);
    at_cycle(e0 + 43); chk("t2_done_e43", 32'(bus.done_o), 32'd1);
    spur = 4'b0000;
    shutdown_pulse();

    // Empty mask.
    do_start(4'b0000);
    chk("t3_busy_e0", 32'(bus.busy_o), 32'd1);
    at_cycle(e0 + 1);
    chk("t3_e1", 32'({bus.core_rst_no, bus.busy_o, bus.done_o}), 32'b0000_0_1);
    shutdown_pulse();

    // Core 2 never answers.
    ready_ok = 4'b1011;
    do_start(4'b1111);
`ifdef BOOT_SEQ_TIMEOUT_EN
    at_cycle(e0 + 88); chk("t4_fail_e88", 32'(bus.fail_o), 32'd0);
    at_cycle(e0 + 89);
    chk("t4_fail_e89", 32'({bus.fail_o, bus.fail_core_o}), 32'b1_10);
    chk("t4_rst_e89", 32'(bus.core_rst_no), 32'b0011);
    chk("t4_nodone", 32'({bus.done_o, bus.busy_o}), 32'd0);
`else
    at_cycle(e0 + 150);
    chk("t4_hang", 32'({bus.core_rst_no, bus.busy_o, bus.fail_o}), 32'b0111_1_0);
`endif
    ready_ok = 4'b1111;
    shutdown_pulse();

    // Shutdown during core 1 stagger.
    do_start(4'b1111);
    at_cycle(e0 + 25);
    chk("t5_mid", 32'(bus.core_rst_no), 32'b0001);
    shutdown_pulse();
    repeat (3) @(negedge clk);
    chk("t5_idle", 32'(outs), 32'd0);

    // Shutdown together with start during core 1 stagger.
    do_start(4'b1111);
    at_cycle(e0 + 25);
    bus.start_i = 1'b1;
    shutdown_pulse();
    bus.start_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5b_idle", 32'(outs), 32'd0);

    // Synchronous reset while waiting on core 0, then reboot.
    do_start(4'b1111);
    at_cycle(e0 + 18);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rst_outs", 32'(outs), 32'd0);
    do_start(4'b1111);
    at_cycle(e0 + 16); chk("t6_rst_e16", 32'(bus.core_rst_no), 32'b0000);
    at_cycle(e0 + 17); chk("t6_rst_e17", 32'(bus.core_rst_no), 32'b0001);
    at_cycle(e0 + 81); chk("t6_done", 32'({bus.core_rst_no, bus.done_o}), 32'b1111_1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
